pipe_de_reg: RTL and testbench
==============================

Name: pipe_de_reg

Overview:
- Decode-to-execute pipeline register of the 32-bit pipelined processor. Sits between the decode stage (control unit, register file, sign extender) and the execute stage (ALU, forwarding muxes).
- Captures every decode-stage control and data field on the rising clock edge and presents it to execute one cycle later.
- CLR clears all fields synchronously; hazard logic uses it to flush (insert a bubble).

Parameters:
- WIDTH, 32, data-path width of RD1, RD2 and SIGN_IMM.

Ports:
- CLK  in  1  clock, rising edge active.
- CLR  in  1  reset/flush; synchronous, active-high.
- REG_WRITE_D  in  1  register-file write enable.
- MEM_TO_REG_D  in  1  writeback source select (memory vs ALU).
- MEM_WRITE_D  in  1  data-memory write enable.
- ALU_CONTROL_D  in  4  ALU operation code.
- ALU_SRC_D  in  2  ALU operand-B source select.
- RD1_D  in  WIDTH  register-file read data 1.
- RD2_D  in  WIDTH  register-file read data 2.
- RA1_D  in  5  read address 1 (used for forwarding).
- RA2_D  in  5  read address 2.
- RS_D  in  5  shift-source register address.
- SIGN_IMM_D  in  WIDTH  sign-extended immediate.
- SHIFT_D  in  3  shift control field.
- WRITE_REG_D  in  5  destination register address.
- REG_WRITE_E, MEM_TO_REG_E, MEM_WRITE_E, ALU_CONTROL_E, ALU_SRC_E, RD1_E, RD2_E, RA1_E, RA2_E, RS_E, SIGN_IMM_E, SHIFT_E, WRITE_REG_E  out  same widths as the _D counterparts  registered copies of the decode inputs.
- STALL_D  in  1  hold enable; present only with PIPE_DE_STALL_EN.

Behaviour:
- Single clock domain: CLK. Reset: CLR, synchronous, active-high.
- All outputs are flops; no combinational path from any input to any output.
- Reset/flush: on a rising CLK edge with CLR=1, every _E output becomes 0, all bits, all fields. This is the bubble: it carries no register write and no memory write.
- Normal operation: on a rising edge with CLR=0, each X_E takes the value X_D had at that edge.
- Latency is exactly 1 cycle. Throughput is one transfer per cycle.
- Outputs are stable between edges. Input changes between edges have no effect.
- CLR asserted mid-stream: the field set presented at that edge is discarded and outputs read 0. The cycle after CLR deasserts, the outputs take the _D values of that cycle.
- CLR held high for several cycles: outputs stay 0.
- Power-up value before the first CLR edge is undefined. The system applies CLR for at least 1 cycle.
- Width rules: bit-exact copy, no sign-extension, no truncation. WIDTH affects only RD1, RD2 and SIGN_IMM.
- All fields are updated together; no field may be written independently of the others.

Optional Feature:
- Macro PIPE_DE_STALL_EN.
- Defined: the STALL_D input exists.
  - On an edge with CLR=0 and STALL_D=1, every _E output holds its current value.
  - CLR has priority over STALL_D: CLR=1 zeroes the outputs regardless of stall.
- Not defined: no STALL_D port; the register loads on every non-CLR edge.

Test Plan:
- Reset: CLR=1 for 1 edge with all inputs driven to nonzero values (e.g. RD1_D=32'hFFFFFFFF, ALU_CONTROL_D=4'hF) -> after that edge every _E output is 0.
- Pass-through: CLR=0, REG_WRITE_D=1, MEM_TO_REG_D=0, MEM_WRITE_D=1, ALU_CONTROL_D=4'hA, ALU_SRC_D=2'b10, RD1_D=32'h12345678, RD2_D=32'hDEADBEEF, RA1_D=5'd3, RA2_D=5'd31, RS_D=5'd7, SIGN_IMM_D=32'hFFFF8000, SHIFT_D=3'b101, WRITE_REG_D=5'd17 -> identical values on the _E outputs after exactly 1 edge, and not before.
- Streaming: 10 consecutive cycles of random inputs with CLR=0 -> on each edge, the _E outputs equal the _D values of the previous cycle.
- Flush mid-stream: a random stream with CLR=1 for one cycle -> outputs 0 for exactly that cycle, then streaming resumes with the next _D values.
- Parameter: WIDTH=16, RD1_D=16'h8001 -> RD1_E=16'h8001, no extension.
- PIPE_DE_STALL_EN defined: load a value, then STALL_D=1 for 3 edges while the inputs change -> outputs unchanged. Then STALL_D=1 with CLR=1 -> outputs 0.

Source files
------------

// File: rtl/pipe_de_reg_if.sv
// Decode/execute bundle: decode-side fields (_D) and their registered copies (_E).
interface pipe_de_reg_if #(
  parameter int WIDTH = 32
);
  logic             REG_WRITE_D;
  logic             MEM_TO_REG_D;
  logic             MEM_WRITE_D;
  logic [3:0]       ALU_CONTROL_D;
  logic [1:0]       ALU_SRC_D;
  logic [WIDTH-1:0] RD1_D;
  logic [WIDTH-1:0] RD2_D;
  logic [4:0]       RA1_D;
  logic [4:0]       RA2_D;
  logic [4:0]       RS_D;
  logic [WIDTH-1:0] SIGN_IMM_D;
  logic [2:0]       SHIFT_D;
  logic [4:0]       WRITE_REG_D;

  logic             REG_WRITE_E;
  logic             MEM_TO_REG_E;
  logic             MEM_WRITE_E;
  logic [3:0]       ALU_CONTROL_E;
  logic [1:0]       ALU_SRC_E;
  logic [WIDTH-1:0] RD1_E;
  logic [WIDTH-1:0] RD2_E;
  logic [4:0]       RA1_E;
  logic [4:0]       RA2_E;
  logic [4:0]       RS_E;
  logic [WIDTH-1:0] SIGN_IMM_E;
  logic [2:0]       SHIFT_E;
  logic [4:0]       WRITE_REG_E;

  modport master (
    output REG_WRITE_D, MEM_TO_REG_D, MEM_WRITE_D, ALU_CONTROL_D,
    output ALU_SRC_D, RD1_D, RD2_D, RA1_D, RA2_D, RS_D,
    output SIGN_IMM_D, SHIFT_D, WRITE_REG_D,
    input  REG_WRITE_E, MEM_TO_REG_E, MEM_WRITE_E, ALU_CONTROL_E,
    input  ALU_SRC_E, RD1_E, RD2_E, RA1_E, RA2_E, RS_E,
    input  SIGN_IMM_E, SHIFT_E, WRITE_REG_E
  );

  modport slave (
    input  REG_WRITE_D, MEM_TO_REG_D, MEM_WRITE_D, ALU_CONTROL_D,
    input  ALU_SRC_D, RD1_D, RD2_D, RA1_D, RA2_D, RS_D,
    input  SIGN_IMM_D, SHIFT_D, WRITE_REG_D,
    output REG_WRITE_E, MEM_TO_REG_E, MEM_WRITE_E, ALU_CONTROL_E,
    output ALU_SRC_E, RD1_E, RD2_E, RA1_E, RA2_E, RS_E,
    output SIGN_IMM_E, SHIFT_E, WRITE_REG_E
  );
endinterface

// File: rtl/pipe_de_reg.sv
// Decode-to-execute pipeline register; CLR inserts a bubble.
// PIPE_DE_STALL_EN adds STALL_D to hold the register (CLR still wins).
module pipe_de_reg #(
  parameter int WIDTH = 32
) (
  input  logic CLK,
  input  logic CLR,
`ifdef PIPE_DE_STALL_EN
  input  logic STALL_D,
`endif
  pipe_de_reg_if.slave de
);

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic [3:0]       alu_control;
    logic [1:0]       alu_src;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [4:0]       rs;
    logic [WIDTH-1:0] sign_imm;
    logic [2:0]       shift;
    logic [4:0]       write_reg;
  } de_t;

  de_t  de_d;
  de_t  de_q;
  logic load;

`ifdef PIPE_DE_STALL_EN
  assign load = !STALL_D;
`else
  assign load = 1'b1;
`endif

  always_comb begin
    de_d = de_q;
    if (load) begin
      de_d.reg_write   = de.REG_WRITE_D;
      de_d.mem_to_reg  = de.MEM_TO_REG_D;
      de_d.mem_write   = de.MEM_WRITE_D;
      de_d.alu_control = de.ALU_CONTROL_D;
      de_d.alu_src     = de.ALU_SRC_D;
      de_d.rd1         = de.RD1_D;
      de_d.rd2         = de.RD2_D;
      de_d.ra1         = de.RA1_D;
      de_d.ra2         = de.RA2_D;
      de_d.rs          = de.RS_D;
      de_d.sign_imm    = de.SIGN_IMM_D;
      de_d.shift       = de.SHIFT_D;
      de_d.write_reg   = de.WRITE_REG_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) de_q <= '0;
    else     de_q <= de_d;
  end

  assign de.REG_WRITE_E   = de_q.reg_write;
  assign de.MEM_TO_REG_E  = de_q.mem_to_reg;
  assign de.MEM_WRITE_E   = de_q.mem_write;
  assign de.ALU_CONTROL_E = de_q.alu_control;
  assign de.ALU_SRC_E     = de_q.alu_src;
  assign de.RD1_E         = de_q.rd1;
  assign de.RD2_E         = de_q.rd2;
  assign de.RA1_E         = de_q.ra1;
  assign de.RA2_E         = de_q.ra2;
  assign de.RS_E          = de_q.rs;
  assign de.SIGN_IMM_E    = de_q.sign_imm;
  assign de.SHIFT_E       = de_q.shift;
  assign de.WRITE_REG_E   = de_q.write_reg;

endmodule

// File: tb/tb_pipe_de_reg.sv
// Bench for pipe_de_reg: directed + random fields against a 1-deep reference.
module tb_pipe_de_reg;
  logic clk = 1'b0;
  logic clr;
  logic stall;

  always #5 clk = ~clk;

  pipe_de_reg_if #(.WIDTH(32)) bus ();
  pipe_de_reg_if #(.WIDTH(16)) bus16 ();

  pipe_de_reg #(.WIDTH(32)) dut (
    .CLK     (clk),
    .CLR     (clr),
`ifdef PIPE_DE_STALL_EN
    .STALL_D (stall),
`endif
    .de      (bus)
  );

  pipe_de_reg #(.WIDTH(16)) dut16 (
    .CLK     (clk),
    .CLR     (clr),
`ifdef PIPE_DE_STALL_EN
    .STALL_D (1'b0),
`endif
    .de      (bus16)
  );

  int total = 0;
  int bad   = 0;
  logic [127:0] expv;
  logic [127:0] held;
  logic [127:0] pt;

  function automatic logic [127:0] dvec();
    return {bus.REG_WRITE_D, bus.MEM_TO_REG_D, bus.MEM_WRITE_D,
            bus.ALU_CONTROL_D, bus.ALU_SRC_D, bus.RD1_D, bus.RD2_D,
            bus.RA1_D, bus.RA2_D, bus.RS_D, bus.SIGN_IMM_D,
            bus.SHIFT_D, bus.WRITE_REG_D};
  endfunction

  function automatic logic [127:0] evec();
    return {bus.REG_WRITE_E, bus.MEM_TO_REG_E, bus.MEM_WRITE_E,
            bus.ALU_CONTROL_E, bus.ALU_SRC_E, bus.RD1_E, bus.RD2_E,
            bus.RA1_E, bus.RA2_E, bus.RS_E, bus.SIGN_IMM_E,
            bus.SHIFT_E, bus.WRITE_REG_E};
  endfunction

  task automatic setd(input logic [127:0] v);
    {bus.REG_WRITE_D, bus.MEM_TO_REG_D, bus.MEM_WRITE_D,
     bus.ALU_CONTROL_D, bus.ALU_SRC_D, bus.RD1_D, bus.RD2_D,
     bus.RA1_D, bus.RA2_D, bus.RS_D, bus.SIGN_IMM_D,
     bus.SHIFT_D, bus.WRITE_REG_D} = v;
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: register captures D (or zero on CLR, or holds on stall).
  task automatic clk_edge(input logic c);
    logic [127:0] dv;
    clr = c;
    dv  = dvec();
    @(posedge clk);
    if (c)           expv = '0;
    else if (!stall) expv = dv;
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] o,
                     input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  initial begin
    stall = 1'b0;
    clr   = 1'b1;
    pt = {1'b1, 1'b0, 1'b1, 4'hA, 2'b10, 32'h12345678, 32'hDEADBEEF,
          5'd3, 5'd31, 5'd7, 32'hFFFF8000, 3'b101, 5'd17};
    {bus16.REG_WRITE_D, bus16.MEM_TO_REG_D, bus16.MEM_WRITE_D,
     bus16.ALU_CONTROL_D, bus16.ALU_SRC_D, bus16.RD1_D, bus16.RD2_D,
     bus16.RA1_D, bus16.RA2_D, bus16.RS_D, bus16.SIGN_IMM_D,
     bus16.SHIFT_D, bus16.WRITE_REG_D} = '0;

    setd('1);
    @(negedge clk);
    clk_edge(1'b1);
    chk("reset", evec(), 128'h0);
    chk("reset16", {112'h0, bus16.RD1_E}, 128'h0);

    setd(pt);
    @(negedge clk);
    chk("pt_before", evec(), 128'h0);
    clk_edge(1'b0);
    chk("pt_after", evec(), pt);

    setd(rnd());
    #2;
    chk("hold_between", evec(), pt);

    for (int i = 0; i < 10; i++) begin
      setd(rnd());
      clk_edge(1'b0);
      chk("stream", evec(), expv);
    end

    for (int i = 0; i < 3; i++) begin
      setd(rnd());
      clk_edge(1'b0);
      chk("pre_flush", evec(), expv);
    end
    setd(rnd());
    clk_edge(1'b1);
    chk("flush", evec(), 128'h0);
    for (int i = 0; i < 3; i++) begin
      setd(rnd());
      clk_edge(1'b0);
      chk("post_flush", evec(), expv);
    end

    for (int i = 0; i < 3; i++) begin
      setd(rnd());
      clk_edge(1'b1);
      chk("clr_held", evec(), 128'h0);
    end
    setd(rnd());
    held = dvec();
    clk_edge(1'b0);
    chk("clr_release", evec(), held);

    bus16.RD1_D = 16'h8001;
    bus16.SIGN_IMM_D = 16'h8000;
    clk_edge(1'b0);
    chk("w16_rd1", {112'h0, bus16.RD1_E}, 128'h8001);
    chk("w16_imm", {112'h0, bus16.SIGN_IMM_E}, 128'h8000);

`ifdef PIPE_DE_STALL_EN
    setd(rnd());
    held = dvec();
    clk_edge(1'b0);
    chk("stall_load", evec(), held);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setd(rnd());
      clk_edge(1'b0);
      chk("stall_hold", evec(), held);
    end
    setd(rnd());
    clk_edge(1'b1);
    chk("stall_clr", evec(), 128'h0);
    stall = 1'b0;
    setd(rnd());
    held = dvec();
    clk_edge(1'b0);
    chk("stall_release", evec(), held);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
